// File: rtl/c7bbiu_rd_sched.sv
// Read-channel scheduler: round-robin sharing of one AXI AR channel between
// IFU, LSU and ICU, with one outstanding read each and R-beat routing by ID.
module c7bbiu_rd_sched #(
   parameter logic [3:0] IFU_ID       = 4'd0,
   parameter logic [3:0] LSU_ID       = 4'd1,
   parameter logic [3:0] ICU_ID       = 4'd2,
   parameter logic [7:0] ICU_LINE_LEN = 8'd3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ifu_req,
   input  logic [31:0] ifu_addr,
   input  logic        ifu_cancel,
   output logic        ifu_ack,
   output logic        ifu_data_valid,
   input  logic        lsu_req,
   input  logic [31:0] lsu_addr,
   output logic        lsu_ack,
   output logic        lsu_data_valid,
   input  logic        icu_req,
   input  logic [28:0] icu_addr,
   input  logic        icu_single,
   output logic        icu_ack,
   output logic        icu_data_valid,
   output logic        icu_data_last,
   output logic        icu_fault,
   output logic [63:0] rdata,
   output logic        ar_valid,
   input  logic        ar_ready,
   output logic [3:0]  ar_id,
   output logic [31:0] ar_addr,
   output logic [7:0]  ar_len,
   output logic [2:0]  ar_size,
   output logic [1:0]  ar_burst,
   output logic        r_ready,
   input  logic        r_valid,
   input  logic [3:0]  r_id,
   input  logic [63:0] r_data,
   input  logic        r_last,
   input  logic [1:0]  r_resp,
   output logic [1:0]  outstanding,
   output logic        id_err
);

   // AR channel handshake: ar_valid rises only from AR_WAIT and the payload is
   // frozen until ar_ready is seen with it; R side always accepts (r_ready=1).
   typedef enum logic {IDLE, AR_WAIT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  req, elig, busy_q, busy_d, set_v, clr_v, beat_v, id_hit;
   logic [1:0]  rr_q, win_d, win_q, outstanding_q;
   logic        load, hs, cancel_q, id_err_q, r_ready_q, ifu_inflight;
   logic [3:0]  ar_id_q, ar_id_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic [7:0]  ar_len_q, ar_len_d;
   logic [1:0]  ar_burst_q, ar_burst_d;

   assign req  = {icu_req, lsu_req, ifu_req};
   assign elig = req & ~busy_q;

   // First eligible requester at or after the round-robin pointer.
   always_comb begin
      win_d = rr_q;
      case (rr_q)
         2'd1: begin
            if (elig[1])      win_d = 2'd1;
            else if (elig[2]) win_d = 2'd2;
            else              win_d = 2'd0;
         end
         2'd2: begin
            if (elig[2])      win_d = 2'd2;
            else if (elig[0]) win_d = 2'd0;
            else              win_d = 2'd1;
         end
         default: begin
            if (elig[0])      win_d = 2'd0;
            else if (elig[1]) win_d = 2'd1;
            else              win_d = 2'd2;
         end
      endcase
   end

   always_comb begin
      ar_id_d    = ICU_ID;
      ar_addr_d  = {icu_addr, 3'b000};
      ar_len_d   = icu_single ? 8'd0 : ICU_LINE_LEN;
      ar_burst_d = icu_single ? 2'b00 : 2'b01;
      case (win_d)
         2'd0: begin
            ar_id_d    = IFU_ID;
            ar_addr_d  = ifu_addr;
            ar_len_d   = 8'd0;
            ar_burst_d = 2'b00;
         end
         2'd1: begin
            ar_id_d    = LSU_ID;
            ar_addr_d  = lsu_addr;
            ar_len_d   = 8'd0;
            ar_burst_d = 2'b00;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      hs       = 1'b0;
      ar_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (|elig) begin
               load    = 1'b1;
               state_d = AR_WAIT;
            end
         end
         AR_WAIT: begin
            ar_valid = 1'b1;
            if (ar_ready) begin
               hs      = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // R routing: a beat belongs to a requester only if its ID matches and it is busy.
   assign id_hit = {r_id == ICU_ID, r_id == LSU_ID, r_id == IFU_ID};
   assign beat_v = {3{r_valid}} & id_hit & busy_q;
   assign clr_v  = beat_v & {3{r_last}};
   assign set_v  = hs ? (3'b001 << win_q) : 3'b000;
   assign busy_d = (busy_q & ~clr_v) | set_v;

   assign ifu_inflight = busy_q[0] | ((state_q == AR_WAIT) && (win_q == 2'd0));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q        <= 3'b000;
         rr_q          <= 2'd0;
         win_q         <= 2'd0;
         cancel_q      <= 1'b0;
         id_err_q      <= 1'b0;
         r_ready_q     <= 1'b0;
         outstanding_q <= 2'd0;
         ar_id_q       <= 4'd0;
         ar_addr_q     <= 32'd0;
         ar_len_q      <= 8'd0;
         ar_burst_q    <= 2'b00;
      end else begin
         r_ready_q     <= 1'b1;
         busy_q        <= busy_d;
         outstanding_q <= {1'b0, busy_d[0]} + {1'b0, busy_d[1]} + {1'b0, busy_d[2]};
         if (load) begin
            win_q      <= win_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_burst_q <= ar_burst_d;
         end
         if (hs) rr_q <= (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
         // Completion of the cancelled IFU read takes precedence over a new cancel.
         if (clr_v[0])                        cancel_q <= 1'b0;
         else if (ifu_cancel && ifu_inflight) cancel_q <= 1'b1;
         if (r_valid && (beat_v == 3'b000)) id_err_q <= 1'b1;
      end
   end

   assign ifu_ack        = set_v[0];
   assign lsu_ack        = set_v[1];
   assign icu_ack        = set_v[2];
   assign ifu_data_valid = beat_v[0] & ~cancel_q;
   assign lsu_data_valid = beat_v[1];
   assign icu_data_valid = beat_v[2];
   assign icu_data_last  = beat_v[2] & r_last;
   assign icu_fault      = beat_v[2] & (r_resp >= 2'b10);
   assign rdata          = r_data;
   assign ar_id          = ar_id_q;
   assign ar_addr        = ar_addr_q;
   assign ar_len         = ar_len_q;
   assign ar_size        = 3'b011;
   assign ar_burst       = ar_burst_q;
   assign r_ready        = r_ready_q;
   assign outstanding    = outstanding_q;
   assign id_err         = id_err_q;

endmodule

// File: tb/tb_c7bbiu_rd_sched.sv
// Bench for c7bbiu_rd_sched: transaction-level model of requesters and AXI slave,
// expected AR/R results queued at issue and checked by a negedge monitor.
module tb_c7bbiu_rd_sched;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        ifu_req = 1'b0, lsu_req = 1'b0, icu_req = 1'b0;
   logic [31:0] ifu_addr = '0, lsu_addr = '0;
   logic [28:0] icu_addr = '0;
   logic        icu_single = 1'b0, ifu_cancel = 1'b0;
   logic        ifu_ack, lsu_ack, icu_ack;
   logic        ifu_data_valid, lsu_data_valid, icu_data_valid, icu_data_last, icu_fault;
   logic [63:0] rdata;
   logic        ar_valid, ar_ready = 1'b0;
   logic [3:0]  ar_id;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        r_ready, r_valid = 1'b0, r_last = 1'b0;
   logic [3:0]  r_id = '0;
   logic [63:0] r_data = '0;
   logic [1:0]  r_resp = '0;
   logic [1:0]  outstanding;
   logic        id_err;

   always #5 clk = ~clk;

   c7bbiu_rd_sched dut (
      .clk(clk), .resetn(resetn),
      .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_cancel(ifu_cancel),
      .ifu_ack(ifu_ack), .ifu_data_valid(ifu_data_valid),
      .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_ack(lsu_ack), .lsu_data_valid(lsu_data_valid),
      .icu_req(icu_req), .icu_addr(icu_addr), .icu_single(icu_single), .icu_ack(icu_ack),
      .icu_data_valid(icu_data_valid), .icu_data_last(icu_data_last), .icu_fault(icu_fault),
      .rdata(rdata),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .r_ready(r_ready), .r_valid(r_valid), .r_id(r_id), .r_data(r_data),
      .r_last(r_last), .r_resp(r_resp),
      .outstanding(outstanding), .id_err(id_err)
   );

   // Expected AR: {ack[icu,lsu,ifu], id, addr, len, burst}; expected R: {dv ifu,lsu,icu, last, fault, data}
   logic [48:0] ar_exp_q[$];
   logic [68:0] r_exp_q[$];
   int          n_tests = 0, n_fail = 0;

   // Requester / slave model: values "_m" hold for the current cycle, "_nx" for the next.
   logic [2:0]  req_m = '0, req_nx = '0, busy_m = '0, busy_nx = '0;
   logic        cancel_m = 0, cancel_nx = 0, id_err_m = 0, id_err_nx = 0;
   logic        ar_live = 0, ar_live_nx = 0, mon_en = 0;
   int          ar_owner = 0, own_beats = 1, rr_m = 0, rr_nx = 0;
   int          rem[3];
   logic [31:0] ifu_a = '0, lsu_a = '0;
   logic [28:0] icu_a = '0;
   logic        icu_s = 1'b0;

   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic miss(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event, expected none queued", name);
   endtask

   always @(negedge clk) begin : monitor
      logic [48:0] e;
      logic [68:0] re;
      if (mon_en) begin
         check("ar_valid", ar_valid, ar_live);
         if (ar_valid) begin
            if (ar_exp_q.size() == 0) miss("ar_unexpected");
            else begin
               e = ar_exp_q[0];
               check("ar_payload", {ar_id, ar_addr, ar_len, ar_burst}, e[45:0]);
               check("ar_size", ar_size, 3'b011);
               if (ar_ready) begin
                  check("acks", {icu_ack, lsu_ack, ifu_ack}, e[48:46]);
                  void'(ar_exp_q.pop_front());
               end
            end
         end
         if (!(ar_valid && ar_ready)) check("acks_idle", {icu_ack, lsu_ack, ifu_ack}, 3'b000);
         if (r_valid) begin
            if (r_exp_q.size() == 0) miss("r_unexpected");
            else begin
               re = r_exp_q.pop_front();
               check("r_beat", {ifu_data_valid, lsu_data_valid, icu_data_valid,
                                icu_data_last, icu_fault, rdata}, re);
            end
         end else begin
            check("dv_idle", {ifu_data_valid, lsu_data_valid, icu_data_valid,
                              icu_data_last, icu_fault}, 5'b0);
         end
         check("outstanding", outstanding, 2'(busy_m[0]) + 2'(busy_m[1]) + 2'(busy_m[2]));
         check("id_err", id_err, id_err_m);
         check("r_ready", r_ready, 1'b1);
      end
   end

   // One clock of stimulus. beat: -1 none, 0..2 next beat of that requester
   // (a stray beat if it is not busy), >=3 a beat with that raw ID.
   task automatic cycle(input logic [2:0] raise, input logic rdy, input int beat, input logic cxl);
      logic [2:0]  elig, dv;
      logic [63:0] d;
      logic [1:0]  resp;
      logic        lst, found;
      int          w;
      @(posedge clk); #1;
      busy_m = busy_nx; cancel_m = cancel_nx; id_err_m = id_err_nx;
      ar_live = ar_live_nx; rr_m = rr_nx;
      req_m = req_nx | raise; req_nx = req_m;
      ifu_req = req_m[0]; lsu_req = req_m[1]; icu_req = req_m[2];
      ifu_addr = ifu_a; lsu_addr = lsu_a; icu_addr = icu_a; icu_single = icu_s;
      ar_ready = rdy; ifu_cancel = cxl;
      if (cxl && (busy_m[0] || (ar_live && ar_owner == 0))) cancel_nx = 1'b1;
      r_valid = 0; r_id = '0; r_data = '0; r_last = 0; r_resp = '0;
      if (beat >= 0) begin
         d = {$urandom, $urandom};
         resp = 2'($urandom_range(0, 3));
         r_valid = 1; r_id = 4'(beat); r_data = d; r_resp = resp;
         if (beat <= 2 && busy_m[beat]) begin
            lst = (rem[beat] == 1);
            r_last = lst;
            rem[beat] = rem[beat] - 1;
            dv = 3'b000;
            dv[beat] = 1'b1;
            if (beat == 0 && cancel_m) dv[0] = 1'b0;
            r_exp_q.push_back({dv[0], dv[1], dv[2], dv[2] & lst, dv[2] & resp[1], d});
            if (lst) begin
               busy_nx[beat] = 1'b0;
               if (beat == 0) cancel_nx = 1'b0;
            end
         end else begin
            r_last = 1'($urandom_range(0, 1));
            r_exp_q.push_back({5'b0, d});
            id_err_nx = 1'b1;
         end
      end
      if (ar_live) begin
         if (rdy) begin
            busy_nx[ar_owner] = 1'b1;
            rem[ar_owner] = own_beats;
            req_nx[ar_owner] = 1'b0;
            rr_nx = (ar_owner + 1) % 3;
            ar_live_nx = 1'b0;
         end
      end else begin
         elig = req_m & ~busy_m;
         found = 1'b0;
         w = 0;
         for (int k = 0; k < 3; k++)
            if (!found && elig[(rr_m + k) % 3]) begin
               found = 1'b1;
               w = (rr_m + k) % 3;
            end
         if (found) begin
            ar_owner = w;
            ar_live_nx = 1'b1;
            if (w == 0)      begin ar_exp_q.push_back({3'b001, 4'd0, ifu_a, 8'd0, 2'b00}); own_beats = 1; end
            else if (w == 1) begin ar_exp_q.push_back({3'b010, 4'd1, lsu_a, 8'd0, 2'b00}); own_beats = 1; end
            else if (icu_s)  begin ar_exp_q.push_back({3'b100, 4'd2, icu_a, 3'b000, 8'd0, 2'b00}); own_beats = 1; end
            else             begin ar_exp_q.push_back({3'b100, 4'd2, icu_a, 3'b000, 8'd3, 2'b01}); own_beats = 4; end
         end
      end
   endtask

   task automatic drain();
      int guard;
      int b;
      guard = 0;
      while ((busy_nx != 3'b000 || ar_live_nx || req_nx != 3'b000) && guard < 100) begin
         b = -1;
         for (int k = 0; k < 3; k++) if (b < 0 && busy_nx[k]) b = k;
         cycle(3'b000, 1'b1, b, 1'b0);
         guard++;
      end
      if (guard >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: busy %b still set after %0d cycles, required 000", busy_nx, guard);
      end
   endtask

   task automatic do_reset();
      mon_en = 0;
      resetn = 0;
      ifu_req = 0; lsu_req = 0; icu_req = 0; ifu_cancel = 0; ar_ready = 0;
      r_valid = 0; r_last = 0; r_id = '0; r_resp = '0;
      #1;
      check("rst_ar_valid", ar_valid, 1'b0);
      check("rst_outstanding", outstanding, 2'd0);
      check("rst_flags", {ifu_ack, lsu_ack, icu_ack, ifu_data_valid, lsu_data_valid,
                          icu_data_valid, icu_fault, id_err, r_ready}, 9'b0);
      check("rst_ar_payload", {ar_id, ar_addr, ar_len, ar_burst}, 46'b0);
      req_m = '0; req_nx = '0; busy_m = '0; busy_nx = '0;
      cancel_m = 0; cancel_nx = 0; id_err_m = 0; id_err_nx = 0;
      ar_live = 0; ar_live_nx = 0; rr_m = 0; rr_nx = 0;
      ar_exp_q.delete();
      r_exp_q.delete();
      repeat (2) @(posedge clk);
      #1 resetn = 1;
      @(posedge clk); #1;
      mon_en = 1;
   endtask

   initial begin
      logic [2:0] raise;
      int         b, s;
      #3;
      do_reset();

      // all three request together; grants come out IFU, LSU, ICU
      icu_s = 0; ifu_a = $urandom; lsu_a = $urandom; icu_a = 29'($urandom);
      cycle(3'b111, 1'b1, -1, 1'b0);
      repeat (6) cycle(3'b000, 1'b1, -1, 1'b0);
      drain();

      // ICU line with ar_ready held low for 5 cycles
      icu_a = 29'h0000_0010; icu_s = 0;
      cycle(3'b100, 1'b0, -1, 1'b0);
      repeat (5) cycle(3'b000, 1'b0, -1, 1'b0);
      cycle(3'b000, 1'b1, -1, 1'b0);
      repeat (4) cycle(3'b000, 1'b0, 2, 1'b0);
      drain();

      // IFU cancel after ack, during AR wait, and with nothing in flight
      ifu_a = $urandom;
      cycle(3'b001, 1'b1, -1, 1'b0);
      cycle(3'b000, 1'b1, -1, 1'b0);
      cycle(3'b000, 1'b0, -1, 1'b1);
      cycle(3'b000, 1'b0, 0, 1'b0);
      cycle(3'b001, 1'b1, -1, 1'b0);
      cycle(3'b000, 1'b1, -1, 1'b0);
      cycle(3'b000, 1'b0, 0, 1'b0);
      cycle(3'b001, 1'b0, -1, 1'b0);
      cycle(3'b000, 1'b0, -1, 1'b1);
      cycle(3'b000, 1'b1, -1, 1'b0);
      cycle(3'b000, 1'b0, 0, 1'b0);
      cycle(3'b000, 1'b0, -1, 1'b1);
      cycle(3'b001, 1'b1, -1, 1'b0);
      drain();

      // LSU completion and IFU AR handshake in the same cycle, LSU re-granted next
      cycle(3'b010, 1'b1, -1, 1'b0);
      cycle(3'b000, 1'b1, -1, 1'b0);
      cycle(3'b001, 1'b0, -1, 1'b0);
      cycle(3'b000, 1'b0, -1, 1'b0);
      cycle(3'b000, 1'b1, 1, 1'b0);
      cycle(3'b010, 1'b1, -1, 1'b0);
      drain();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         raise = 3'b000;
         for (int k = 0; k < 3; k++)
            if (!req_nx[k] && $urandom_range(0, 3) == 0) begin
               raise[k] = 1'b1;
               if (k == 0)      ifu_a = $urandom;
               else if (k == 1) lsu_a = $urandom;
               else begin icu_a = 29'($urandom); icu_s = 1'($urandom_range(0, 1)); end
            end
         b = -1;
         if ($urandom_range(0, 1) == 1) begin
            s = $urandom_range(0, 2);
            for (int k = 0; k < 3; k++) if (b < 0 && busy_nx[(s + k) % 3]) b = (s + k) % 3;
         end
         cycle(raise, 1'($urandom_range(0, 1)), b, ($urandom_range(0, 15) == 0) && (b != 0));
      end
      drain();

      // stray beats: unknown ID, then LSU while idle
      cycle(3'b000, 1'b0, 7, 1'b0);
      cycle(3'b000, 1'b0, 1, 1'b0);
      repeat (3) cycle(3'b000, 1'b0, -1, 1'b0);

      // reset while IFU waits on AR and ICU is busy; IFU wins first afterwards
      icu_s = 1;
      cycle(3'b100, 1'b1, -1, 1'b0);
      cycle(3'b000, 1'b1, -1, 1'b0);
      cycle(3'b001, 1'b0, -1, 1'b0);
      cycle(3'b000, 1'b0, -1, 1'b0);
      do_reset();
      icu_s = 0;
      cycle(3'b111, 1'b1, -1, 1'b0);
      drain();
      repeat (2) cycle(3'b000, 1'b0, -1, 1'b0);

      check("ar_q_empty", 69'(ar_exp_q.size()), 69'd0);
      check("r_q_empty", 69'(r_exp_q.size()), 69'd0);
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
